// File: rtl/untrusted_ram_arb.sv
// rtl/untrusted_ram_arb.sv - round-robin arbiter sharing the untrusted RAM between Ibex fetch and data ports
// Bounds/write-protect checks, local error responses and fixed 1-cycle response routing.
module untrusted_ram_arb #(
  parameter int unsigned AddrBits = 15,
  parameter logic [31:0] RamBase  = 32'h0010_0000,
  parameter int unsigned WpWords  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                instr_req_i,
  output logic                instr_gnt_o,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,

  input  logic                data_req_i,
  output logic                data_gnt_o,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_rvalid_o,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o,

  input  logic                wp_en_i,

  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [AddrBits-1:0] ram_addr_o,
  output logic [31:0]         ram_wdata_o,
  output logic [31:0]         ram_mask_o,
  input  logic                ram_rvalid_i,
  input  logic [31:0]         ram_rdata_i,
  input  logic                ram_err_i,

  output logic                protocol_err_o
);

  typedef enum logic {
    SIDE_INSTR = 1'b0,
    SIDE_DATA  = 1'b1
  } side_e;

  localparam logic [32:0] RangeBytes = 33'(1) << (AddrBits + 2);
  localparam logic [30:0] WpLimit    = 31'(WpWords);

  side_e       rr_last_q, rr_last_d;
  logic        pend_valid_q, pend_valid_d;
  side_e       pend_owner_q, pend_owner_d;
  logic        pend_local_q, pend_local_d;
  logic        prot_err_q, prot_err_d;

  logic        gnt_instr, gnt_data, any_gnt;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [32:0] offset;
  logic        in_range, wp_hit, local_err;

  // Grants are suppressed during reset so nothing is accepted that would be dropped.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        gnt_instr = (rr_last_q == SIDE_DATA);
        gnt_data  = (rr_last_q == SIDE_INSTR);
      end else begin
        gnt_instr = instr_req_i;
        gnt_data  = data_req_i;
      end
    end
  end

  assign any_gnt     = gnt_instr | gnt_data;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  assign sel_addr = gnt_data ? data_addr_i : instr_addr_i;
  assign sel_be   = gnt_data ? data_be_i : 4'hF;

  // 33-bit subtraction: addresses below the base wrap to a huge offset and fail the range test.
  assign offset    = {1'b0, sel_addr} - {1'b0, RamBase};
  assign in_range  = (offset < RangeBytes);
  assign wp_hit    = gnt_data & data_we_i & wp_en_i & (offset[32:2] < WpLimit);
  assign local_err = ~in_range | wp_hit;

  always_comb begin
    ram_mask_o = '0;
    for (int i = 0; i < 4; i++) begin
      ram_mask_o[i*8 +: 8] = {8{sel_be[i]}};
    end
  end

  assign ram_req_o   = any_gnt & ~local_err;
  assign ram_we_o    = ram_req_o & gnt_data & data_we_i;
  assign ram_addr_o  = offset[AddrBits+1:2];
  assign ram_wdata_o = data_wdata_i;

  logic        fwd_pending;
  logic        emit;
  logic        resp_err;
  logic [31:0] resp_rdata;

  assign fwd_pending = pend_valid_q & ~pend_local_q;
  assign emit        = pend_valid_q & ~rst_i;

  // A forwarded entry without its RAM response still answers, as an error.
  always_comb begin
    resp_err   = 1'b1;
    resp_rdata = '0;
    if (fwd_pending && ram_rvalid_i) begin
      resp_err   = ram_err_i;
      resp_rdata = ram_rdata_i;
    end
  end

  assign instr_rvalid_o = emit & (pend_owner_q == SIDE_INSTR);
  assign data_rvalid_o  = emit & (pend_owner_q == SIDE_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : '0;
  assign instr_err_o    = instr_rvalid_o & resp_err;
  assign data_rdata_o   = data_rvalid_o ? resp_rdata : '0;
  assign data_err_o     = data_rvalid_o & resp_err;

  always_comb begin
    rr_last_d    = rr_last_q;
    pend_valid_d = any_gnt;
    pend_owner_d = gnt_data ? SIDE_DATA : SIDE_INSTR;
    pend_local_d = local_err;
    prot_err_d   = prot_err_q;
    if (any_gnt) begin
      rr_last_d = gnt_data ? SIDE_DATA : SIDE_INSTR;
    end
    if ((ram_rvalid_i && !fwd_pending) || (fwd_pending && !ram_rvalid_i)) begin
      prot_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q    <= SIDE_DATA;
      pend_valid_q <= 1'b0;
      pend_owner_q <= SIDE_INSTR;
      pend_local_q <= 1'b0;
      prot_err_q   <= 1'b0;
    end else begin
      rr_last_q    <= rr_last_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      pend_local_q <= pend_local_d;
      prot_err_q   <= prot_err_d;
    end
  end

  assign protocol_err_o = prot_err_q;

endmodule

// File: tb/tb_untrusted_ram_arb.sv
// tb/tb_untrusted_ram_arb.sv - scoreboard bench for untrusted_ram_arb with behavioural RAM and reference model
module tb_untrusted_ram_arb;

  localparam int unsigned AW       = 15;
  localparam logic [31:0] RAM_BASE = 32'h0010_0000;
  localparam longint      RAM_BYTES = 4 * (64'd1 << AW);
  localparam longint      WP_WORDS = 1024;
  localparam int          ERR_WORD = 7;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        wp_en_i;
  logic        ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0] ram_wdata_o, ram_mask_o;
  logic        ram_rvalid_i = 1'b0;
  logic [31:0] ram_rdata_i = '0;
  logic        ram_err_i = 1'b0;
  logic        protocol_err_o;

  untrusted_ram_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .wp_en_i(wp_en_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_mask_o(ram_mask_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i), .ram_err_i(ram_err_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM macro: answers every request exactly one cycle later.
  logic [31:0] env_mem [0:(1<<AW)-1];
  bit          inject = 1'b0;
  always @(posedge clk_i) begin
    ram_rvalid_i <= ram_req_o | inject;
    ram_err_i    <= ram_req_o && (int'(ram_addr_o) == ERR_WORD);
    ram_rdata_i  <= (ram_req_o && !ram_we_o) ? env_mem[ram_addr_o] : 32'h0;
    if (ram_req_o && ram_we_o)
      env_mem[ram_addr_o] <= (env_mem[ram_addr_o] & ~ram_mask_o) | (ram_wdata_o & ram_mask_o);
  end

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] shadow [0:(1<<AW)-1];
  bit          last_data;

  always @(negedge clk_i) begin
    if (!rst_i && (instr_rvalid_o || data_rvalid_o)) begin
      if (instr_rvalid_o && data_rvalid_o) begin
        chk("dual_rvalid", {instr_rvalid_o, data_rvalid_o}, 32'h1);
      end else if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'h1, 32'h0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_port", data_rvalid_o, e.is_data);
        if (e.is_data) begin
          chk("data_rdata", data_rdata_o, e.rdata);
          chk("data_err", data_err_o, e.err);
          chk("idle_instr_rdata", {instr_rdata_o[30:0], instr_err_o}, 32'h0);
        end else begin
          chk("instr_rdata", instr_rdata_o, e.rdata);
          chk("instr_err", instr_err_o, e.err);
          chk("idle_data_rdata", {data_rdata_o[30:0], data_err_o}, 32'h0);
        end
      end
    end
  end

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                      input bit wp);
    bit gi, gd, inr, lerr;
    longint off, word;
    logic [31:0] a, mask;
    logic [3:0] be;
    resp_t e;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
    wp_en_i = wp;
    #1;
    gi = ir && (!dr || last_data);
    gd = dr && !gi;
    chk("instr_gnt", instr_gnt_o, gi);
    chk("data_gnt", data_gnt_o, gd);
    if (gi || gd) begin
      a    = gi ? ia : da;
      off  = longint'(a) - longint'(RAM_BASE);
      word = off / 4;
      inr  = (off >= 0) && (off < RAM_BYTES);
      lerr = !inr || (gd && dwe && wp && word < WP_WORDS);
      chk("ram_req", ram_req_o, !lerr);
      e.is_data = gd;
      if (lerr) begin
        e.rdata = 32'h0;
        e.err   = 1'b1;
      end else begin
        be = gd ? dbe : 4'hF;
        for (int i = 0; i < 4; i++) mask[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        chk("ram_addr", ram_addr_o, word[31:0]);
        chk("ram_we", ram_we_o, gd && dwe);
        chk("ram_mask", ram_mask_o, mask);
        e.err = (word == ERR_WORD);
        if (gd && dwe) begin
          chk("ram_wdata", ram_wdata_o, dwd);
          shadow[word] = (shadow[word] & ~mask) | (dwd & mask);
          e.rdata = 32'h0;
        end else begin
          e.rdata = shadow[word];
        end
      end
      sb.push_back(e);
      last_data = gd;
    end else begin
      chk("ram_req_idle", ram_req_o, 1'b0);
    end
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom % 16;
    if (r == 0) return RAM_BASE + 32'h0002_0000 + 4 * ($urandom % 4);
    if (r == 1) return RAM_BASE - 4 * (1 + $urandom % 4);
    if (r < 4)  return RAM_BASE + 32'h0FF0 + 4 * ($urandom % 8);
    return RAM_BASE + 4 * ($urandom % 64);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    rst_i = 1'b1;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_be_i = 0; data_addr_i = 0; data_wdata_i = 0; wp_en_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    last_data = 1'b1;
    chk("reset_prot_err", protocol_err_o, 1'b0);
    chk("reset_rvalid", {instr_rvalid_o, data_rvalid_o}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Seed a few words, then the directed scenarios.
    step(0, 0, 1, 1, 4'hF, RAM_BASE + 32'h8, 32'hCAFE_F00D, 0);
    step(1, RAM_BASE + 32'h8, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, RAM_BASE + 4 * i, 1, 0, 4'hF, RAM_BASE + 32'h8, 0, 0);
    step(0, 0, 1, 1, 4'b0101, RAM_BASE + 32'h10, 32'h1234_5678, 0);
    step(0, 0, 1, 0, 4'hF, RAM_BASE + 32'h10, 0, 0);
    step(0, 0, 1, 1, 4'hF, RAM_BASE + 32'h0FFC, 32'hDEAD_BEEF, 1);
    step(0, 0, 1, 1, 4'hF, RAM_BASE + 32'h1000, 32'hDEAD_BEEF, 1);
    step(0, 0, 1, 0, 4'hF, RAM_BASE + 32'h2_0000, 0, 0);
    step(0, 0, 1, 0, 4'hF, RAM_BASE - 32'h4, 0, 0);
    step(1, RAM_BASE + 4 * ERR_WORD, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++)
      step($urandom % 2, rand_addr(), $urandom % 2, $urandom % 2, 4'($urandom),
           rand_addr(), $urandom, $urandom % 2);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);
    chk("no_prot_err", protocol_err_o, 1'b0);

    inject = 1'b1;
    @(posedge clk_i); #1 inject = 1'b0;
    @(posedge clk_i); #1;
    chk("spurious_prot_err", protocol_err_o, 1'b1);
    @(posedge clk_i); #1;
    chk("prot_err_sticky", protocol_err_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk("prot_err_cleared", protocol_err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/untrusted_ram_arb.md
Name: untrusted_ram_arb

Overview:
- Shares the untrusted device's single-port RAM between the Ibex instruction-fetch port and the Ibex data port.
- Sits between the core-side routing logic and the RAM macro.
- Arbitrates round-robin, checks bounds and write protection, and routes each fixed-latency RAM response back to the requester that issued it.
- Synthesises error responses locally for rejected accesses, with the same latency as a RAM response.

Parameters:
- AddrBits, 15, RAM word-address width. RAM size is 2^AddrBits words.
- RamBase, 32'h0010_0000, byte base address of the RAM window.
- WpWords, 1024, number of words from RamBase that are write-protected while wp_en_i=1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_addr_i  in  32  fetch byte address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  data write data
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error
- wp_en_i  in  1  write-protect enable for the low WpWords region
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  AddrBits  RAM word address
- ram_wdata_o  out  32  RAM write data
- ram_mask_o  out  32  RAM bit mask, byte enables expanded to bits
- ram_rvalid_i  in  1  RAM response valid, exactly 1 cycle after ram_req_o
- ram_rdata_i  in  32  RAM read data
- ram_err_i  in  1  RAM error
- protocol_err_o  out  1  sticky flag: RAM response mismatch

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: every registered output 0. The rr_last pointer resets to DATA, so INSTR wins first contention.
- Grant rules:
  - At most one grant per cycle. Grant is combinational, same cycle as req.
  - Only one requester active: it is granted.
  - Both requesters active: grant the one not equal to rr_last.
  - rr_last updates to the granted side on every grant.
- Range check: a request is in range iff (addr - RamBase) < 2^AddrBits * 4. Computed in 33 bits; no wrap-around acceptance.
- Write-protect hit: data_we_i=1, wp_en_i=1, and word offset < WpWords.
- Local error: out-of-range or write-protect hit.
  - The request is still granted.
  - ram_req_o stays 0.
  - A local-error entry is recorded.
- Forwarded request:
  - ram_req_o=1.
  - ram_addr_o = offset[AddrBits+1:2].
  - ram_we_o = data_we_i for the data port, 0 for the instruction port.
  - ram_mask_o has byte i = 8'hFF if be[i], else 8'h00. The instruction port uses be = 4'hF.
  - ram_wdata_o = data_wdata_i.
- Response pipeline register, 1 stage, captured on every grant: {valid, owner, local_err}.
- Response in cycle t+1 for a grant in cycle t; latency is exactly 1 cycle for all cases.
  - Owner INSTR: pulse instr_rvalid_o. Owner DATA: pulse data_rvalid_o.
  - RAM case: rdata = ram_rdata_i, err = ram_err_i.
  - Local-error case: rdata = 0, err = 1.
  - The non-owner's rvalid, rdata and err are all 0.
- No response backpressure: the core always accepts rvalid.
- protocol_err_o is set and held until reset in either case:
  - ram_rvalid_i=1 when the pipeline does not hold a forwarded (non-local) entry.
  - A forwarded entry is pending and ram_rvalid_i=0.
- On a protocol error, the pending entry still responds with err=1 and rdata=0.
- Reset mid-operation: the pending entry is dropped, no rvalid is emitted, and protocol_err_o clears.
- A ram_rvalid_i arriving in the first cycle after reset sets protocol_err_o.
- Simultaneous events: a new grant in the same cycle a response is emitted is allowed, giving back-to-back throughput of one access per cycle.

Test Plan:
- Reset, then instr_req_i=1 at RamBase+0x8 -> instr_gnt_o=1 and ram_addr_o=2 that cycle; next cycle instr_rvalid_o=1 with the RAM data, data_rvalid_o=0.
- Both requests held 4 cycles -> grants alternate INSTR, DATA, INSTR, DATA; 4 responses routed to the matching port.
- Data write be=4'b0101 at RamBase+0x10 -> ram_we_o=1, ram_mask_o=32'h00FF00FF, ram_addr_o=4.
- wp_en_i=1, data write at RamBase+0x0FFC -> granted, ram_req_o=0, next cycle data_err_o=1. The same write at RamBase+0x1000 -> forwarded.
- Data read at RamBase+0x20000 (out of range), also RamBase-4 -> local error response, err=1, no ram_req_o.
- Spurious ram_rvalid_i with nothing pending -> protocol_err_o=1 and stays 1; assert rst_i one cycle -> 0.
